// File: rtl/pipe_rca_pkg.sv
// Shared constants for the pipelined ripple-carry adder.
package pipe_rca_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  function automatic int stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// One SEG-bit ripple-carry chain; also exposes the carry into its top bit for overflow detection.
module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  logic c;

  always_comb begin
    c        = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipe_rca.sv
// Pipelined add/subtract: one SEG-bit ripple segment per stage, latency WIDTH/SEG cycles.
// Whole pipeline stalls when the output holds a result that downstream does not take.
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stages(WIDTH, SEG);

  if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_bad_params
    $error("pipe_rca: WIDTH must be a non-zero multiple of SEG");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Each stage register packs {upper a, upper b, completed sum bits}.
    localparam int RW = WIDTH - k * SEG;
    localparam int SW = (k + 1) * SEG;
    localparam int DW = 2 * (RW - SEG) + SW;

    logic [RW-1:0]  a_in, b_in;
    logic           c_in, v_in;
    logic [SEG-1:0] seg_s;
    logic           seg_co, seg_cm;
    logic [SW-1:0]  s_new;
    logic [DW-1:0]  d_nxt, d_q;
    logic           v_q, c_q;

    if (k == 0) begin : g_first
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign s_new = seg_s;
    end else begin : g_next
      localparam int PDW = 2 * RW + k * SEG;
      assign a_in  = g_stage[k-1].d_q[PDW-1 -: RW];
      assign b_in  = g_stage[k-1].d_q[PDW-RW-1 -: RW];
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_new = {seg_s, g_stage[k-1].d_q[k*SEG-1:0]};
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a        (a_in[SEG-1:0]),
      .b        (b_in[SEG-1:0]),
      .ci       (c_in),
      .s        (seg_s),
      .co       (seg_co),
      .c_msb_in (seg_cm)
    );

    // Data registers load only on real operands so outputs hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        d_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= seg_co;
          d_q <= d_nxt;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic cm_unused;
      assign d_nxt     = {a_in[RW-1:SEG], b_in[RW-1:SEG], s_new};
      assign cm_unused = seg_cm;
    end else begin : g_last
      logic m_q;
      assign d_nxt = s_new;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_q <= 1'b0;
        end else if (en && v_in) begin
          m_q <= seg_cm;
        end
      end

      assign out_valid = v_q;
      assign s         = d_q;
      assign cout      = c_q;
      assign ovf       = c_q ^ m_q;
    end
  end

endmodule

// File: tb/tb_pipe_rca.sv
// Randomised and directed checks of pipe_rca against an arithmetic reference model.
module tb_pipe_rca;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, s;

  logic       in_valid4, in_ready4, cin4, out_valid4, cout4, ovf4;
  logic [3:0] a4, b4, s4;

  always #5 clk = ~clk;

  pipe_rca #(.WIDTH(16), .SEG(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  pipe_rca #(.WIDTH(4), .SEG(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(1'b0), .out_valid(out_valid4),
    .out_ready(1'b1), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t       q[$];
  logic [5:0] q4[$];
  int         nvec  = 0;
  int         nfail = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    res_t r;
    int ux, uy, sx, sy, ures, sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      ures = ux - uy;
      sres = sx - sy;
      r.c  = (ux >= uy);
    end else begin
      ures = ux + uy + int'(ci);
      sres = sx + sy + int'(ci);
      r.c  = (ures > 65535);
    end
    r.s = ures[15:0];
    r.o = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  // Scoreboard for the 16-bit instance
  logic        stalled = 1'b0;
  logic [15:0] held_s;
  logic        held_c, held_o;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      res_t e;
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", {15'd0, held_c, held_o, s}, {15'd0, cout, ovf, held_s});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", {15'd0, s, cout, ovf}, {15'd0, e});
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      stalled = out_valid && !out_ready;
      held_s  = s;
      held_c  = cout;
      held_o  = ovf;
    end
  end

  // Scoreboard for the 4-bit instance
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
    end else begin
      int sum, ssum;
      logic [5:0] e4;
      if (out_valid4) begin
        if (q4.size() == 0) begin
          chk("spurious_out4", 32'd1, 32'd0);
        end else begin
          e4 = q4.pop_front();
          chk("result4", {26'd0, cout4, ovf4, s4}, {26'd0, e4});
        end
      end
      if (in_valid4 && in_ready4) begin
        sum  = int'(a4) + int'(b4) + int'(cin4);
        ssum = int'($signed(a4)) + int'($signed(b4)) + int'(cin4);
        q4.push_back({sum > 15, (ssum > 7) || (ssum < -8), sum[3:0]});
      end
    end
  end

  task automatic one_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input logic sb, input logic [15:0] es, input logic ec,
                        input logic eo, input string name);
    int t0;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_latency"}, seen ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'(LAT));
    chk({name, "_s"}, 32'(s), 32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    res_t       r;
    bit         hist[24];
    int         first, vsum;
    logic [15:0] held;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #11 rst_n = 1'b1;

    r = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("model_wrap", 32'(r), {15'd0, 16'h0000, 1'b1, 1'b0});
    r = model(16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("model_sub_ovf", 32'(r), {15'd0, 16'h7FFF, 1'b1, 1'b1});

    idle(2);
    one_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    one_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    one_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    idle(6);

    // Back-to-back stream must come out as one unbroken burst
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 8);
      a = 16'(i); b = 16'(i * 16'h1111); cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      hist[i] = out_valid;
    end
    first = -1;
    for (int i = 0; i < 24; i++) if (hist[i] && first < 0) first = i;
    chk("b2b_first", 32'(first), 32'(LAT));
    if (first >= 0 && first + 8 < 24) begin
      for (int j = 0; j < 8; j++) chk("b2b_burst", 32'(hist[first+j]), 32'd1);
      chk("b2b_end", 32'(hist[first+8]), 32'd0);
    end
    idle(4);

    // Backpressure with the pipeline full
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    held = s;
    repeat (6) @(negedge clk);
    chk("bp_s_held", 32'(s), 32'(held));
    idle(10);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (i % 97 == 0) begin a = 16'h7FFF; b = 16'h8000; end
    end
    idle(12);
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Exhaustive single-segment adder
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          @(posedge clk); #1;
          in_valid4 = 1'b1; a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c);
        end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("exh4_drained", 32'(q4.size()), 32'd0);

    // Asynchronous reset with three operands in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'h1234 + 16'(i); b = 16'h4321; cin = 1'b1; sub = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_s", 32'(s), 32'd0);
    chk("arst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    vsum = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vsum += int'(out_valid);
    end
    chk("arst_no_stale", 32'(vsum), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    nfail++;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
